cronotermostato: RTL

CRONOTERMOSTATO -- requirements
Module: cronotermostato

---
 rtl/cronotermostato_pkg.sv | 16 +
 rtl/cronotermostato_if.sv | 12 +
 rtl/cronotermostato_sp_table.sv | 28 ++
 rtl/cronotermostato.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cronotermostato_pkg.sv
// Shared types and default constants for the chrono-thermostat.
// The ANTIFREEZE_EN macro is consumed by the top module.
package cronotermostato_pkg;
  typedef enum logic [1:0] {
    OFF  = 2'd0,
    IDLE = 2'd1,
    HEAT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int P_DEF_SP  = 40;
  localparam int P_HYST    = 2;
  localparam int P_MIN_ON  = 5;
  localparam int P_MIN_OFF = 3;
  localparam int P_ACC_W   = 11;
endpackage

// File: rtl/cronotermostato_if.sv
// Setpoint table write port.
// master drives the write, slave (the thermostat) receives it.
interface cronotermostato_if #(
  parameter int TW = 8
);
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [TW-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/cronotermostato_sp_table.sv
// Per-hour setpoint storage with write port and registered read.
// Out-of-range addresses are ignored on write and hold sp_cur on read.
module sp_table #(
  parameter int SX_MAX = 6,
  parameter int TW     = 8,
  parameter int DEF_SP = 40
) (
  input  logic                clk,
  input  logic                rst,
  cronotermostato_if.slave    wr,
  input  logic [2:0]          ora,
  output logic [TW-1:0]       sp_cur
);
  logic [TW-1:0] r_tab [SX_MAX];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SX_MAX; i++)
        r_tab[i] <= TW'(DEF_SP);
      sp_cur <= TW'(DEF_SP);
    end else begin
      if (wr.wr_en && (32'(wr.wr_addr) < SX_MAX))
        r_tab[wr.wr_addr] <= wr.wr_data;
      if (32'(ora) < SX_MAX)
        sp_cur <= r_tab[ora];
    end
  end
endmodule

// File: rtl/cronotermostato.sv
// Chrono-thermostat: hysteresis FSM with minimum on/off times and daily log.
// Optional `ANTIFREEZE_EN: heat from OFF when temp < AF_TEMP.
module cronotermostato
  import cronotermostato_pkg::*;
#(
  parameter int SX_MAX  = 6,
  parameter int DX_MAX  = 60,
  parameter int TW      = 8,
  parameter int DEF_SP  = P_DEF_SP,
  parameter int HYST    = P_HYST,
  parameter int MIN_ON  = P_MIN_ON,
  parameter int MIN_OFF = P_MIN_OFF
`ifdef ANTIFREEZE_EN
  ,
  parameter int AF_TEMP = 10
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2:0]         ora,
  input  logic [5:0]         minuti,
  input  logic               done,
  input  logic [TW-1:0]      temp,
  cronotermostato_if.slave   wr,
  output logic               heater_on,
  output logic [TW-1:0]      sp_cur,
  output logic [1:0]         stato,
  output logic [P_ACC_W-1:0] heat_min_day
);
  localparam int MW = $clog2(DX_MAX);
  localparam int CW = 8;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [5:0]         r_min_prev;
  logic [P_ACC_W-1:0] r_acc;
  logic               w_tick;
  logic               w_af;
  logic [TW:0]        w_sum;
  logic [TW-1:0]      w_lo;
  logic [TW-1:0]      w_hi;
  logic [P_ACC_W-1:0] w_acc_nxt;

  sp_table #(
    .SX_MAX (SX_MAX),
    .TW     (TW),
    .DEF_SP (DEF_SP)
  ) u_sp_table (
    .clk    (clk),
    .rst    (rst),
    .wr     (wr),
    .ora    (ora),
    .sp_cur (sp_cur)
  );

  assign w_tick = minuti[MW-1:0] != r_min_prev[MW-1:0];
  assign w_sum  = {1'b0, sp_cur} + (TW+1)'(HYST);
  assign w_lo   = (sp_cur >= TW'(HYST)) ? sp_cur - TW'(HYST) : '0;

`ifdef ANTIFREEZE_EN
  logic r_af;
  assign w_af = r_af;
  // Antifreeze heating uses a fixed upper threshold
  assign w_hi = r_af ? TW'(AF_TEMP + HYST)
              : (w_sum[TW] ? '1 : w_sum[TW-1:0]);
`else
  assign w_af = 1'b0;
  assign w_hi = w_sum[TW] ? '1 : w_sum[TW-1:0];
`endif

  assign w_acc_nxt =
    ((r_state == HEAT) && w_tick && (r_acc != '1))
    ? r_acc + 1'b1 : r_acc;

  assign stato = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_min_prev   <= '0;
      r_acc        <= '0;
      heat_min_day <= '0;
    end else begin
      r_min_prev <= minuti;
      if (done) begin
        heat_min_day <= w_acc_nxt;
        r_acc        <= '0;
      end else begin
        r_acc <= w_acc_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= OFF;
      heater_on <= 1'b0;
      r_cnt     <= '0;
`ifdef ANTIFREEZE_EN
      r_af      <= 1'b0;
`endif
    end else begin
      if (w_tick && (r_cnt != '0))
        r_cnt <= r_cnt - 1'b1;
      unique case (r_state)
        OFF: begin
          if (en) begin
            r_state   <= IDLE;
            heater_on <= 1'b0;
          end
`ifdef ANTIFREEZE_EN
          else if (temp < TW'(AF_TEMP)) begin
            r_state   <= HEAT;
            heater_on <= 1'b1;
            r_cnt     <= CW'(MIN_ON);
            r_af      <= 1'b1;
          end
`endif
        end
        IDLE: begin
          if (!en) begin
            r_state <= OFF;
          end else if (temp < w_lo) begin
            r_state   <= HEAT;
            heater_on <= 1'b1;
            r_cnt     <= CW'(MIN_ON);
          end
        end
        HEAT: begin
          if (!en && !w_af) begin
            r_state   <= OFF;
            heater_on <= 1'b0;
          end else if ((temp >= w_hi) && (r_cnt == '0)) begin
            r_state   <= HOLD;
            heater_on <= 1'b0;
            r_cnt     <= CW'(MIN_OFF);
`ifdef ANTIFREEZE_EN
            r_af      <= 1'b0;
`endif
          end
        end
        HOLD: begin
          if (!en)
            r_state <= OFF;
          else if (r_cnt == '0)
            r_state <= IDLE;
        end
        default: r_state <= OFF;
      endcase
    end
  end
endmodule
